// File: rtl/router_in_port.sv
// Router-side receiver for one node link: deserializes 4-byte packets into a
// first-word-fall-through packet FIFO and drives the link's free flow control.
module router_in_port #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            put_inbound,
   input  logic [7:0]                      payload_inbound,
   output logic                            free_inbound,
   output logic [31:0]                     pkt_out,
   output logic                            pkt_out_valid,
   input  logic                            pkt_out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            proto_err
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StB1, StB2, StB3} state_e;

   state_e            state_q, state_d;
   logic [23:0]       shift_q;
   logic [31:0]       mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              free_q, free_d;
   logic              err_q, err_d;
   logic              push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (put_inbound) begin
               if (free_q) state_d = StB1;
               else        err_d   = 1'b1;
            end
         end
         StB1: begin
            if (put_inbound) state_d = StB2;
            else begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StB2: begin
            if (put_inbound) state_d = StB3;
            else begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StB3: begin
            state_d = StIdle;
            if (put_inbound) push  = 1'b1;
            else             err_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      pop     = (count_q != '0) && pkt_out_ready;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;

      // Free is granted one edge ahead, so it looks at the post-edge state and occupancy.
      free_d = (state_d == StIdle) && (count_d < CntW'(FIFO_DEPTH));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         free_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         free_q  <= free_d;
         err_q   <= err_d;
         if (state_d != StIdle) shift_q <= {shift_q[15:0], payload_inbound};
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   // Storage needs no reset: contents are only visible through a non-zero count.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {shift_q, payload_inbound};
   end

   assign pkt_out       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign pkt_out_valid = (count_q != '0);
   assign fifo_count    = count_q;
   assign free_inbound  = free_q;
   assign proto_err     = err_q;

   a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && count_q == CntW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_router_in_port.sv
// Randomized self-checking bench for router_in_port against a queue-based packet model.
module tb_router_in_port;

   localparam int unsigned Depth = 4;
   localparam int unsigned CntW  = $clog2(Depth + 1);

   logic            clock = 1'b0;
   logic            reset_n;
   logic            put_inbound;
   logic [7:0]      payload_inbound;
   logic            free_inbound;
   logic [31:0]     pkt_out;
   logic            pkt_out_valid;
   logic            pkt_out_ready;
   logic [CntW-1:0] fifo_count;
   logic            proto_err;

   router_in_port #(.FIFO_DEPTH(Depth)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .put_inbound     (put_inbound),
      .payload_inbound (payload_inbound),
      .free_inbound    (free_inbound),
      .pkt_out         (pkt_out),
      .pkt_out_valid   (pkt_out_valid),
      .pkt_out_ready   (pkt_out_ready),
      .fifo_count      (fifo_count),
      .proto_err       (proto_err)
   );

   always #5 clock = ~clock;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] q[$];
   bit          err_model = 1'b0;
   bit          in_pkt = 1'b0;
   int          rdy_mode = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state();
      check("count", 32'(fifo_count), 32'(q.size()));
      check("valid", 32'(pkt_out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("pkt_out", pkt_out, q[0]);
      else               check("pkt_out_idle", pkt_out, 32'h0);
      check("free", 32'(free_inbound), 32'(!in_pkt && q.size() < Depth));
      check("proto_err", 32'(proto_err), 32'(err_model));
   endtask

   // One clock edge; the model applies pop-then-push and then compares.
   task automatic step(input bit put, input logic [7:0] b, input bit push_now,
                       input logic [31:0] p);
      bit r;
      bit pop;
      put_inbound     = put;
      payload_inbound = b;
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      pkt_out_ready = r;
      pop = r && (q.size() != 0);
      @(posedge clock);
      #1;
      if (pop) void'(q.pop_front());
      if (push_now) q.push_back(p);
      check_state();
   endtask

   task automatic wait_free(output int waited);
      waited = 0;
      in_pkt = 1'b0;
      while (!free_inbound && waited < 200) begin
         step(1'b0, 8'h00, 1'b0, 32'h0);
         waited++;
      end
      if (!free_inbound) check("free_timeout", 32'(free_inbound), 32'h1);
   endtask

   task automatic send_pkt(input logic [31:0] p, output int waited);
      wait_free(waited);
      in_pkt = 1'b1;
      step(1'b1, p[31:24], 1'b0, p);
      step(1'b1, p[23:16], 1'b0, p);
      step(1'b1, p[15:8], 1'b0, p);
      in_pkt = 1'b0;
      step(1'b1, p[7:0], 1'b1, p);
   endtask

   task automatic send_partial(input int nbytes);
      int w;
      wait_free(w);
      in_pkt = 1'b1;
      for (int j = 0; j < nbytes; j++) step(1'b1, 8'($urandom), 1'b0, 32'h0);
      in_pkt    = 1'b0;
      err_model = 1'b1;
      step(1'b0, 8'h00, 1'b0, 32'h0);
   endtask

   task automatic idle(input int n);
      in_pkt = 1'b0;
      for (int j = 0; j < n; j++) step(1'b0, 8'h00, 1'b0, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fill [4];
      int          w;
      fill[0] = 32'h12345678;
      fill[1] = 32'h9ABCDEF0;
      fill[2] = 32'h0FEDCBA9;
      fill[3] = 32'h87654321;

      reset_n = 1'b0;
      put_inbound = 1'b0;
      payload_inbound = 8'h00;
      pkt_out_ready = 1'b0;
      #12;
      check("rst_free", 32'(free_inbound), 32'h0);
      check("rst_valid", 32'(pkt_out_valid), 32'h0);
      check("rst_count", 32'(fifo_count), 32'h0);
      check("rst_pkt", pkt_out, 32'h0);
      check("rst_err", 32'(proto_err), 32'h0);
      reset_n = 1'b1;
      idle(1);

      // First packet: visible right after the 4th byte edge.
      send_pkt(32'h05EAF00D, w);
      check("t1_pkt", pkt_out, 32'h05EAF00D);
      check("t1_valid", 32'(pkt_out_valid), 32'h1);
      rdy_mode = 1;
      idle(2);

      // Fill the FIFO with ready low, then a single pop releases free.
      rdy_mode = 0;
      for (int i = 0; i < 4; i++) send_pkt(fill[i], w);
      check("t2_count", 32'(fifo_count), 32'd4);
      check("t2_free", 32'(free_inbound), 32'h0);
      check("t2_head", pkt_out, 32'h12345678);
      rdy_mode = 1;
      idle(1);
      check("t2_after_pop", pkt_out, 32'h9ABCDEF0);
      check("t2_free_rel", 32'(free_inbound), 32'h1);
      idle(3);
      check("t2_drained", 32'(pkt_out_valid), 32'h0);

      // Stream with ready high: free must never make the sender wait.
      for (int i = 0; i < 6; i++) begin
         send_pkt($urandom, w);
         check("stream_nowait", 32'(w), 32'h0);
      end
      idle(2);

      // Truncated packet, then a clean one.
      rdy_mode = 0;
      send_partial(2);
      check("t4_err", 32'(proto_err), 32'h1);
      send_pkt(32'hF2F3F4F5, w);
      check("t4_pkt", pkt_out, 32'hF2F3F4F5);
      rdy_mode = 1;
      idle(2);

      // Reset pulse in B2 with two packets buffered.
      rdy_mode = 0;
      send_pkt($urandom, w);
      send_pkt($urandom, w);
      in_pkt = 1'b1;
      step(1'b1, 8'hA1, 1'b0, 32'h0);
      step(1'b1, 8'hA2, 1'b0, 32'h0);
      reset_n = 1'b0;
      put_inbound = 1'b0;
      #1;
      check("t5_count", 32'(fifo_count), 32'h0);
      check("t5_valid", 32'(pkt_out_valid), 32'h0);
      check("t5_free", 32'(free_inbound), 32'h0);
      check("t5_err", 32'(proto_err), 32'h0);
      @(posedge clock);
      #1;
      check("t5_free_hold", 32'(free_inbound), 32'h0);
      reset_n = 1'b1;
      q.delete();
      err_model = 1'b0;
      idle(1);
      send_pkt(32'h01020304, w);
      check("t5_pkt", pkt_out, 32'h01020304);

      // Random traffic with random ready and occasional protocol faults.
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6) begin
            send_pkt($urandom, w);
         end else if (r == 6) begin
            send_partial($urandom_range(1, 3));
         end else if (r == 7 && !free_inbound) begin
            err_model = 1'b1;
            in_pkt = 1'b0;
            step(1'b1, 8'hEE, 1'b0, 32'h0);
         end else begin
            idle($urandom_range(1, 3));
         end
      end
      rdy_mode = 1;
      idle(6);
      check("final_empty", 32'(fifo_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
